router_pkt_tx: RTL and testbench

Packet transmitter for the 1x3 router input port. It accepts a packet request and its payload bytes from a local byte source and buffers the whole payload. It then drives the router's `packet_valid`/`data` inputs with header, payload and parity, honouring the router's `busy` back-pressure. It sits upstream of the router's input FSM and is the source end of that protocol.

---
 rtl/router_pkg.sv | 40 ++++
 rtl/router_tx_buf.sv | 25 ++
 rtl/router_pkt_tx.sv | 157 +++++++++++++++
 tb/tb_router_pkt_tx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: FSM states,
// header field layout and byte-level helper functions.
package router_pkg;

  localparam int MAX_LEN   = 63;
  localparam int LEN_W     = 6;
  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 64;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PARITY  = 3'd4,
    ST_GAP     = 3'd5
  } tx_state_e;

  function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0] len,
                                                    input logic [1:0]       addr);
    logic [DATA_W-1:0] hdr;
    hdr = 8'h00;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
    return hdr;
  endfunction

  function automatic logic [DATA_W-1:0] parity_update(input logic [DATA_W-1:0] acc,
                                                      input logic [DATA_W-1:0] byte_in);
    return acc ^ byte_in;
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store: 64x8 register array, one synchronous write port and one
// combinational read port. Storage is deliberately left unreset.
module router_tx_buf
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              wr_en,
  input  logic [LEN_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LEN_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [BUF_DEPTH];

  // Write one payload byte per accepted handshake.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers a whole payload, then sends
// header, payload and parity under the router's busy back-pressure.
module router_pkt_tx
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        dest_addr,
  input  logic [LEN_W-1:0]  payload_len,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic              busy,
  output logic              packet_valid,
  output logic [DATA_W-1:0] data,
  output logic              idle,
  output logic              done,
  output logic              err
);

  tx_state_e         state_r;
  logic              pv_r;
  logic [DATA_W-1:0] data_r;
  logic              pl_ready_r;
  logic              done_r;
  logic              err_r;
  logic              idle_r;
  logic [LEN_W-1:0]  wr_cnt_r;
  logic [LEN_W-1:0]  rd_ptr_r;
  logic [DATA_W-1:0] parity_r;
  logic [LEN_W-1:0]  len_r;
  logic [1:0]        addr_r;

  logic              wr_en_s;
  logic [LEN_W-1:0]  rd_addr_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [LEN_W-1:0]  len_last_s;

  assign wr_en_s    = (state_r == ST_LOAD) && pl_valid && pl_ready_r;
  assign len_last_s = len_r - 6'd1;

  // Read address looks one byte ahead so data is ready on the consuming edge.
  always_comb begin
    rd_addr_s = 6'd0;
    if (state_r == ST_HEADER) begin
      rd_addr_s = 6'd0;
    end else begin
      rd_addr_s = rd_ptr_r + 6'd1;
    end
  end

  router_tx_buf u_buf (
    .clock   (clock),
    .wr_en   (wr_en_s),
    .wr_addr (wr_cnt_r),
    .wr_data (pl_data),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Transmit FSM with all outputs, counters and parity registered.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      pv_r       <= 1'b0;
      data_r     <= 8'h00;
      pl_ready_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      idle_r     <= 1'b1;
      wr_cnt_r   <= 6'd0;
      rd_ptr_r   <= 6'd0;
      parity_r   <= 8'h00;
      len_r      <= 6'd0;
      addr_r     <= 2'd0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if ((dest_addr == ADDR_INVALID) || (payload_len == 6'd0)) begin
              err_r <= 1'b1;
            end else begin
              len_r      <= payload_len;
              addr_r     <= dest_addr;
              parity_r   <= make_header(payload_len, dest_addr);
              wr_cnt_r   <= 6'd0;
              pl_ready_r <= 1'b1;
              idle_r     <= 1'b0;
              state_r    <= ST_LOAD;
            end
          end
        end
        // busy is irrelevant while filling the buffer.
        ST_LOAD: begin
          if (pl_valid && pl_ready_r) begin
            parity_r <= parity_update(parity_r, pl_data);
            wr_cnt_r <= wr_cnt_r + 6'd1;
            if (wr_cnt_r == len_last_s) begin
              pl_ready_r <= 1'b0;
              pv_r       <= 1'b1;
              data_r     <= make_header(len_r, addr_r);
              state_r    <= ST_HEADER;
            end
          end
        end
        ST_HEADER: begin
          if (!busy) begin
            rd_ptr_r <= 6'd0;
            data_r   <= rd_data_s;
            state_r  <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (!busy) begin
            if (rd_ptr_r == len_last_s) begin
              pv_r    <= 1'b0;
              data_r  <= parity_r;
              state_r <= ST_PARITY;
            end else begin
              rd_ptr_r <= rd_ptr_r + 6'd1;
              data_r   <= rd_data_s;
            end
          end
        end
        ST_PARITY: begin
          if (!busy) begin
            done_r  <= 1'b1;
            data_r  <= 8'h00;
            state_r <= ST_GAP;
          end
        end
        ST_GAP: begin
          idle_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          pv_r       <= 1'b0;
          data_r     <= 8'h00;
          pl_ready_r <= 1'b0;
          idle_r     <= 1'b1;
        end
      endcase
    end
  end

  assign packet_valid = pv_r;
  assign data         = data_r;
  assign pl_ready     = pl_ready_r;
  assign done         = done_r;
  assign err          = err_r;
  assign idle         = idle_r;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomized bench for router_pkt_tx: a queue-based packet model predicts
// the byte stream the router should see under random busy and pl_valid.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dest_addr = 2'd0;
  logic [5:0] payload_len = 6'd0;
  logic [7:0] pl_data = 8'h00;
  logic       pl_valid = 1'b0;
  logic       busy = 1'b0;
  logic       pl_ready, packet_valid, idle, done, err;
  logic [7:0] data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  router_pkt_tx dut (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start),
    .dest_addr    (dest_addr),
    .payload_len  (payload_len),
    .pl_data      (pl_data),
    .pl_valid     (pl_valid),
    .pl_ready     (pl_ready),
    .busy         (busy),
    .packet_valid (packet_valid),
    .data         (data),
    .idle         (idle),
    .done         (done),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ignored traffic on start/pl_valid while the block is busy with a packet.
  task automatic noise();
    start       = ($urandom_range(0, 3) == 0);
    dest_addr   = 2'($urandom);
    payload_len = 6'($urandom);
  endtask

  // busy_mode: 0 none, 1 random, 2 header stall x3, 3 parity stall x2
  // valid_mode: 0 always, 1 every other cycle, 2 random
  // pat: 1 uses bytes A1 B2 C3; hdr_k/par_k nonzero add constant checks
  task automatic send_packet(input logic [1:0] addr, input int len, input int busy_mode,
                             input int valid_mode, input int abort_item, input int pat,
                             input logic [7:0] hdr_k, input logic [7:0] par_k);
    logic [7:0] items[$];
    logic [7:0] tbl[3];
    logic [7:0] par;
    int got, cyc, idx, stall;
    logic adv;
    tbl[0] = 8'hA1; tbl[1] = 8'hB2; tbl[2] = 8'hC3;
    @(negedge clock);
    check("idle_before", idle, 1);
    start = 1'b1; dest_addr = addr; payload_len = len[5:0]; busy = 1'b0;
    @(negedge clock);
    par = {len[5:0], addr};
    items.push_back(par);
    got = 0; cyc = 0;
    while (got < len && cyc < 1000) begin
      check("pl_ready_load", pl_ready, 1);
      check("idle_load", idle, 0);
      check("pv_load", packet_valid, 0);
      check("err_ignored", err, 0);
      case (valid_mode)
        0:       pl_valid = 1'b1;
        1:       pl_valid = (cyc % 2 == 0);
        default: pl_valid = 1'($urandom_range(0, 1));
      endcase
      pl_data = (pat == 1) ? tbl[got % 3] : 8'($urandom);
      busy = 1'($urandom_range(0, 1));
      noise();
      if (pl_valid) begin
        items.push_back(pl_data);
        par = par ^ pl_data;
        got++;
      end
      @(negedge clock);
      cyc++;
    end
    if (got < len) check("load_timeout", 0, 1);
    items.push_back(par);
    idx = 0; stall = 0; cyc = 0;
    while (idx < len + 2 && cyc < 2000) begin
      check("pv", packet_valid, (idx <= len));
      check("data", data, items[idx]);
      check("done_early", done, 0);
      check("pl_ready_tx", pl_ready, 0);
      check("err_tx", err, 0);
      if (idx == 0 && hdr_k != 8'h00) check("hdr_const", data, hdr_k);
      if (idx == len + 1 && par_k != 8'h00) check("par_const", data, par_k);
      if (abort_item == idx) begin
        #2 resetn = 1'b0;
        #1;
        check("rst_pv", packet_valid, 0);
        check("rst_data", data, 0);
        check("rst_idle", idle, 1);
        check("rst_pl_ready", pl_ready, 0);
        start = 1'b0; pl_valid = 1'b0; busy = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        return;
      end
      case (busy_mode)
        0:       busy = 1'b0;
        1:       busy = 1'($urandom_range(0, 1));
        2:       busy = (idx == 0 && stall < 3);
        3:       busy = (idx == len + 1 && stall < 2);
        default: busy = 1'b0;
      endcase
      noise();
      pl_valid = 1'($urandom_range(0, 1));
      adv = !busy;
      @(negedge clock);
      cyc++;
      if (adv) begin idx++; stall = 0; end
      else stall++;
    end
    if (idx < len + 2) check("tx_timeout", 0, 1);
    start = 1'b0;
    busy = 1'($urandom_range(0, 1));
    check("done", done, 1);
    check("gap_pv", packet_valid, 0);
    check("gap_data", data, 0);
    check("gap_idle", idle, 0);
    @(negedge clock);
    check("idle_after", idle, 1);
    check("done_once", done, 0);
    pl_valid = 1'b0;
    busy = 1'b0;
  endtask

  task automatic send_bad(input logic [1:0] addr, input logic [5:0] len);
    @(negedge clock);
    start = 1'b1; dest_addr = addr; payload_len = len; busy = 1'b0;
    @(negedge clock);
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_idle", idle, 1);
    check("err_pl_ready", pl_ready, 0);
    check("err_pv", packet_valid, 0);
    @(negedge clock);
    check("err_clear", err, 0);
    check("err_pv2", packet_valid, 0);
    check("err_pl_ready2", pl_ready, 0);
  endtask

  initial begin
    #12;
    check("reset_pv", packet_valid, 0);
    check("reset_data", data, 0);
    check("reset_pl_ready", pl_ready, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_idle", idle, 1);
    @(negedge clock);
    resetn = 1'b1;

    send_packet(2'd1, 3, 0, 0, -1, 1, 8'h0D, 8'hDD);
    send_packet(2'd1, 3, 2, 0, -1, 1, 8'h0D, 8'hDD);
    send_packet(2'd1, 3, 3, 0, -1, 1, 8'h0D, 8'hDD);
    send_bad(2'd3, 6'd5);
    send_bad(2'd0, 6'd0);
    send_packet(2'd2, 63, 1, 1, -1, 0, 8'hFE, 8'h00);
    send_packet(2'd0, 4, 0, 0, 3, 0, 8'h10, 8'h00);
    send_packet(2'd0, 4, 0, 0, -1, 0, 8'h10, 8'h00);
    for (int k = 0; k < 6; k++) begin
      send_packet(2'($urandom_range(0, 2)), $urandom_range(1, 63), 1, 2, -1, 0, 8'h00, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
